// File: rtl/sram_arb.sv
// ---------------------------------------------------------------------------
// sram_arb
// Single-port arbiter and timing sequencer for the 256Kx16 async SRAM at
// 108 MHz. Two clients share the SRAM: the SXGA video fetch (read-only,
// priority) and the AVR DAP host port. The block owns every sram_* pin and
// produces the host rq_ack handshake.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   v_rq_i, v_addr_i      video word request (level) and address
//   v_ack_o               pulse: video address taken, present the next one
//   v_data_o, v_valid_o   video read data and its one-cycle valid strobe
//   h_addr_i, h_d_wr_i    host word address and write data
//   h_w_rq_i, h_r_rq_i    host write / read request pulses
//   h_rq_ack_o            high = host port idle; low while a request is open
//   h_d_rd_o              host read data, held until the next host read ends
//   sram_*                SRAM data bus, address and active-low controls
// ---------------------------------------------------------------------------
module sram_arb #(
    parameter int HOST_MAX_WAIT = 16,
    parameter int HOST_AW       = 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               v_rq_i,
    input  logic [17:0]        v_addr_i,
    output logic               v_ack_o,
    output logic [15:0]        v_data_o,
    output logic               v_valid_o,
    input  logic [HOST_AW-1:0] h_addr_i,
    input  logic [15:0]        h_d_wr_i,
    input  logic               h_w_rq_i,
    input  logic               h_r_rq_i,
    output logic               h_rq_ack_o,
    output logic [15:0]        h_d_rd_o,
    inout  wire  [15:0]        sram_dq_io,
    output logic [17:0]        sram_addr_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    output logic               sram_ub_n_o,
    output logic               sram_lb_n_o
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, WR2} state_e;

    localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);

    state_e            state_q, state_d;
    logic              grant_host, grant_vid;

    // Pending host request
    logic              pend_q, pend_write_q;
    logic [17:0]       pend_addr_q;
    logic [15:0]       pend_data_q;
    logic [WAIT_W-1:0] wait_q;
    logic              oor_done_q, oor_read_q;

    // Access in flight belongs to the host (1) or to video (0)
    logic              owner_host_q;

    // Registered SRAM pins
    logic              ce_n_q, oe_n_q, we_n_q, be_n_q, dq_oe_q;
    logic              ce_n_d, oe_n_d, we_n_d, be_n_d, dq_oe_d;
    logic [17:0]       addr_q;
    logic [15:0]       dq_out_q;

    // Registered client outputs
    logic              v_ack_q, v_valid_q, h_rq_ack_q;
    logic [15:0]       v_data_q, h_d_rd_q;

    // A request is only accepted while the host port reports idle.
    logic              host_req, host_oor, cap_ok, cap_oor, host_elig, wait_sat;
    logic              elig_write;
    logic [17:0]       elig_addr;
    logic [15:0]       elig_data;

    assign host_req  = h_rq_ack_q & (h_w_rq_i | h_r_rq_i);
    assign host_oor  = |h_addr_i[HOST_AW-1:18];
    assign cap_ok    = host_req & ~host_oor;
    assign cap_oor   = host_req & host_oor;
    assign wait_sat  = (wait_q >= WAIT_W'(HOST_MAX_WAIT));

    // A request captured on this very edge competes alongside a stored one.
    assign host_elig  = pend_q | cap_ok;
    assign elig_write = pend_q ? pend_write_q : h_w_rq_i;
    assign elig_addr  = pend_q ? pend_addr_q  : h_addr_i[17:0];
    assign elig_data  = pend_q ? pend_data_q  : h_d_wr_i;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // -----------------------------------------------------------------------
    // Next-state and grant logic. IDLE, RD1 and WR2 are arbitration points,
    // so back-to-back accesses need no idle cycle between them.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d    = state_q;
        grant_host = 1'b0;
        grant_vid  = 1'b0;
        case (state_q)
            RD0:     state_d = RD1;
            WR0:     state_d = WR1;
            WR1:     state_d = WR2;
            default: begin
                if (host_elig && (!v_rq_i || wait_sat)) begin
                    grant_host = 1'b1;
                    state_d    = elig_write ? WR0 : RD0;
                end else if (v_rq_i) begin
                    grant_vid = 1'b1;
                    state_d   = RD0;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // SRAM control values for the state being entered; registered below so
    // the pins change cleanly on the clock edge.
    // -----------------------------------------------------------------------
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            RD0, RD1: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 1'b0;
            end
            WR0, WR2: begin
                ce_n_d  = 1'b0;
                be_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            WR1: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            be_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
            addr_q       <= '0;
            dq_out_q     <= '0;
            owner_host_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_write_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            wait_q       <= '0;
            oor_done_q   <= 1'b0;
            oor_read_q   <= 1'b0;
            v_ack_q      <= 1'b0;
            v_valid_q    <= 1'b0;
            v_data_q     <= '0;
            h_rq_ack_q   <= 1'b1;
            h_d_rd_q     <= '0;
        end else begin
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            dq_oe_q <= dq_oe_d;

            if (grant_host) begin
                addr_q       <= elig_addr;
                dq_out_q     <= elig_data;
                owner_host_q <= 1'b1;
            end else if (grant_vid) begin
                addr_q       <= v_addr_i;
                owner_host_q <= 1'b0;
            end
            v_ack_q   <= grant_vid;
            v_valid_q <= 1'b0;

            // Write wins when both request strobes arrive together.
            if (cap_ok) begin
                pend_write_q <= h_w_rq_i;
                pend_addr_q  <= h_addr_i[17:0];
                pend_data_q  <= h_d_wr_i;
            end
            if (grant_host)  pend_q <= 1'b0;
            else if (cap_ok) pend_q <= 1'b1;

            if (grant_host)                 wait_q <= '0;
            else if (host_elig && !wait_sat) wait_q <= wait_q + 1'b1;

            if (host_req) h_rq_ack_q <= 1'b0;

            // Out-of-range requests never touch the SRAM; they finish one
            // cycle after capture.
            oor_done_q <= cap_oor;
            if (cap_oor) oor_read_q <= ~h_w_rq_i;
            if (oor_done_q) begin
                h_rq_ack_q <= 1'b1;
                if (oor_read_q) h_d_rd_q <= 16'hFFFF;
            end

            // Read data is sampled on the edge leaving RD1.
            if (state_q == RD1) begin
                if (owner_host_q) begin
                    h_d_rd_q   <= sram_dq_io;
                    h_rq_ack_q <= 1'b1;
                end else begin
                    v_data_q  <= sram_dq_io;
                    v_valid_q <= 1'b1;
                end
            end
            if (state_q == WR2) h_rq_ack_q <= 1'b1;
        end
    end

    assign sram_dq_io  = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign sram_addr_o = addr_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_oe_n_o = oe_n_q;
    assign sram_we_n_o = we_n_q;
    assign sram_ub_n_o = be_n_q;
    assign sram_lb_n_o = be_n_q;
    assign v_ack_o     = v_ack_q;
    assign v_data_o    = v_data_q;
    assign v_valid_o   = v_valid_q;
    assign h_rq_ack_o  = h_rq_ack_q;
    assign h_d_rd_o    = h_d_rd_q;

endmodule

// File: tb/tb_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_sram_arb
// Directed self-checking bench for sram_arb. A behavioural async SRAM sits on
// the pins; a weak-purpose "probe" driver puts 0x0F0F on the data bus so an
// undriven bus reads back exactly 0x0F0F, while any DUT drive corrupts it.
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_sram_arb;

    localparam int HOST_AW = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               v_rq;
    logic [17:0]        v_addr;
    logic               v_ack, v_valid;
    logic [15:0]        v_data;
    logic [HOST_AW-1:0] h_addr;
    logic [15:0]        h_d_wr;
    logic               h_w_rq, h_r_rq;
    logic               h_rq_ack;
    logic [15:0]        h_d_rd;
    wire  [15:0]        sram_dq;
    logic [17:0]        sram_addr;
    logic               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [4:0]         ctrl;

    logic               probe_en = 1'b0;
    logic [15:0]        mem [0:262143];
    int                 we_low_cnt = 0;
    logic [17:0]        last_wr_addr = '0;
    logic [15:0]        last_wr_data = '0;

    int                 checks = 0;
    int                 errors = 0;

    logic [15:0] exp_vid [8] = '{16'h1000, 16'h2101, 16'h3202, 16'h4303,
                                 16'h5404, 16'h6505, 16'h7606, 16'h8707};

    sram_arb #(.HOST_MAX_WAIT(16), .HOST_AW(HOST_AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .v_rq_i      (v_rq),
        .v_addr_i    (v_addr),
        .v_ack_o     (v_ack),
        .v_data_o    (v_data),
        .v_valid_o   (v_valid),
        .h_addr_i    (h_addr),
        .h_d_wr_i    (h_d_wr),
        .h_w_rq_i    (h_w_rq),
        .h_r_rq_i    (h_r_rq),
        .h_rq_ack_o  (h_rq_ack),
        .h_d_rd_o    (h_d_rd),
        .sram_dq_io  (sram_dq),
        .sram_addr_o (sram_addr),
        .sram_ce_n_o (sram_ce_n),
        .sram_oe_n_o (sram_oe_n),
        .sram_we_n_o (sram_we_n),
        .sram_ub_n_o (sram_ub_n),
        .sram_lb_n_o (sram_lb_n)
    );

    always #5 clk = ~clk;

    assign ctrl = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};

    // SRAM model: reads are combinational, writes land while we_n is low.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
    assign sram_dq = probe_en ? 16'h0F0F : 16'hzzzz;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr] = sram_dq;
            last_wr_addr   = sram_addr;
            last_wr_data   = sram_dq;
            we_low_cnt     = we_low_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus_released(input string tag);
        probe_en = 1'b1;
        #1;
        chk(tag, sram_dq, 16'h0F0F);
        probe_en = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [HOST_AW-1:0] a, input logic [15:0] exp);
        h_addr = a;
        h_r_rq = 1'b1;
        tick();
        h_r_rq = 1'b0;
        tick();
        tick();
        chk(tag, {h_rq_ack, h_d_rd}, {1'b1, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int acks;
        int last_ack;
        int n_valid;
        int ack_rise;
        int acks_wait;
        logic ack_at_18;
        int vq[$];

        rst = 1'b1; v_rq = 1'b0; v_addr = '0;
        h_addr = '0; h_d_wr = '0; h_w_rq = 1'b0; h_r_rq = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = exp_vid[i];
        mem[18'h10] = 16'h1234;
        mem[18'h20] = 16'h0000;

        // ---- 1: reset state and a quiet idle period ----
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ctrl", ctrl, 5'b11111);
        chk("rst_addr", sram_addr, 18'h0);
        chk("rst_host", {h_rq_ack, h_d_rd}, {1'b1, 16'h0000});
        chk("rst_video", {v_ack, v_valid, v_data}, {2'b00, 16'h0000});
        chk_bus_released("rst_dq_z");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_hold", {ctrl, h_rq_ack, v_ack, v_valid}, {5'b11111, 1'b1, 2'b00});
        end
        chk("idle_no_write", we_low_cnt, 0);

        // ---- 2: host read of 0x10 ----
        h_addr = 24'h000010;
        h_r_rq = 1'b1;
        tick();
        h_r_rq = 1'b0;
        chk("hrd_rd0", {ctrl, sram_addr, h_rq_ack}, {5'b00100, 18'h10, 1'b0});
        tick();
        chk("hrd_rd1", {ctrl, sram_addr, h_rq_ack}, {5'b00100, 18'h10, 1'b0});
        tick();
        chk("hrd_done", {ctrl, h_rq_ack, h_d_rd}, {5'b11111, 1'b1, 16'h1234});

        // ---- 3: host write at the top address, then read it back ----
        wc = we_low_cnt;
        h_addr = 24'h03FFFF;
        h_d_wr = 16'hA55A;
        h_w_rq = 1'b1;
        tick();
        h_w_rq = 1'b0;
        chk("hwr_wr0", {ctrl, sram_addr, h_rq_ack}, {5'b01100, 18'h3FFFF, 1'b0});
        tick();
        chk("hwr_wr1", {ctrl, sram_addr, h_rq_ack}, {5'b01000, 18'h3FFFF, 1'b0});
        tick();
        chk("hwr_wr2", {ctrl, h_rq_ack}, {5'b01100, 1'b0});
        tick();
        chk("hwr_done", {ctrl, h_rq_ack}, {5'b11111, 1'b1});
        chk("hwr_we_pulses", we_low_cnt - wc, 1);
        chk("hwr_bus", {last_wr_addr, last_wr_data}, {18'h3FFFF, 16'hA55A});
        host_read("hwr_readback", 24'h03FFFF, 16'hA55A);

        // ---- 4: video burst over addresses 0..7 ----
        v_addr = '0;
        v_rq = 1'b1;
        acks = 0;
        last_ack = 0;
        n_valid = 0;
        for (int c = 0; c < 40 && n_valid < 8; c++) begin
            tick();
            if (v_valid) begin
                if (vq.size() != 0) chk("vid_data", v_data, exp_vid[vq.pop_front()]);
                else chk("vid_spurious_valid", v_valid, 1'b0);
                n_valid++;
            end
            if (v_ack) begin
                if (acks > 0) chk("vid_ack_gap", c - last_ack, 2);
                last_ack = c;
                vq.push_back(int'(v_addr[2:0]));
                acks++;
                if (acks == 8) v_rq = 1'b0;
                else v_addr = v_addr + 18'd1;
            end
        end
        chk("vid_counts", {acks[7:0], n_valid[7:0]}, {8'd8, 8'd8});
        tick();
        chk("vid_idle_after", ctrl, 5'b11111);

        // ---- 5: host read starved by continuous video ----
        v_addr = '0;
        v_rq = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (v_ack) begin
                vq.push_back(int'(v_addr[2:0]));
                v_addr = (v_addr + 18'd1) & 18'h7;
                break;
            end
        end
        tick();  // mid-access edge; the next edge is an arbitration point
        h_addr = 24'h000010;
        h_r_rq = 1'b1;
        ack_rise = -1;
        acks_wait = 0;
        ack_at_18 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k == 0) h_r_rq = 1'b0;
            if (v_valid) begin
                if (vq.size() != 0) chk("arb_vid_data", v_data, exp_vid[vq.pop_front()]);
                else chk("arb_spurious_valid", v_valid, 1'b0);
            end
            if (v_ack) begin
                if (k < 16) acks_wait++;
                if (k == 18) ack_at_18 = 1'b1;
                vq.push_back(int'(v_addr[2:0]));
                v_addr = (v_addr + 18'd1) & 18'h7;
            end
            if (k == 16) chk("arb_host_slot", {sram_addr, sram_oe_n, v_ack}, {18'h10, 1'b0, 1'b0});
            if (h_rq_ack && ack_rise < 0) ack_rise = k;
        end
        v_rq = 1'b0;
        chk("arb_host_done_cycle", ack_rise, 18);
        chk("arb_host_data", h_d_rd, 16'h1234);
        chk("arb_video_before_grant", acks_wait, 8);
        chk("arb_video_resumes", ack_at_18, 1'b1);
        for (int c = 0; c < 10 && vq.size() > 0; c++) begin
            tick();
            if (v_valid) chk("arb_drain_data", v_data, exp_vid[vq.pop_front()]);
        end
        chk("arb_no_lost_words", vq.size(), 0);
        tick();

        // ---- 6a: out-of-range host read ----
        wc = we_low_cnt;
        h_addr = 24'h400000;
        h_r_rq = 1'b1;
        tick();
        h_r_rq = 1'b0;
        chk("oor_capture", {ctrl, h_rq_ack}, {5'b11111, 1'b0});
        tick();
        chk("oor_done", {ctrl, h_rq_ack, h_d_rd}, {5'b11111, 1'b1, 16'hFFFF});

        // ---- 6b: write and read strobed together: write only ----
        h_addr = 24'h000020;
        h_d_wr = 16'hBEEF;
        h_w_rq = 1'b1;
        h_r_rq = 1'b1;
        tick();
        h_w_rq = 1'b0;
        h_r_rq = 1'b0;
        chk("both_is_write", {ctrl, sram_addr}, {5'b01100, 18'h20});
        tick();
        tick();
        tick();
        chk("both_done", {h_rq_ack, h_d_rd}, {1'b1, 16'hFFFF});
        chk("both_we_pulses", we_low_cnt - wc, 1);
        chk("both_mem", mem[18'h20], 16'hBEEF);
        tick();
        chk("both_no_read", ctrl, 5'b11111);

        // ---- 6c: reset in the middle of a write ----
        h_addr = 24'h000030;
        h_d_wr = 16'h5A5A;
        h_w_rq = 1'b1;
        tick();
        h_w_rq = 1'b0;
        tick();
        chk("rstwr_in_wr1", sram_we_n, 1'b0);
        rst = 1'b1;
        tick();
        chk("rstwr_ctrl", {ctrl, h_rq_ack, v_ack, v_valid}, {5'b11111, 1'b1, 2'b00});
        chk("rstwr_addr", sram_addr, 18'h0);
        chk_bus_released("rstwr_dq_z");
        rst = 1'b0;
        tick();
        chk("rstwr_idle", {ctrl, h_rq_ack}, {5'b11111, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
